ahb_lite_fir_slave_gen: RTL and testbench

//  Parametrised AHB-Lite slave; the bus front-end of the FIR filter peripheral.

---
 rtl/ahb_lite_fir_slave_gen.sv | 277 +++++++++++++++++++++++++++
 tb/tb_ahb_lite_fir_slave_gen.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_fir_slave_gen.sv
// AHB-Lite bus front-end of the FIR filter peripheral.
// Holds the coefficient bank and the coefficient-set flag, buffers samples in a
// small FIFO, stalls sample writes while that FIFO is full and issues the
// two-cycle ERROR response for illegal accesses.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  ST_IDLE  | no data phase in progress
//  ST_DATA  | data phase of an accepted, legal transfer (may stall)
//  ST_ERR1  | first ERROR cycle  (hreadyout=0, hresp=1)
//  ST_ERR2  | second ERROR cycle (hreadyout=1, hresp=1)
module ahb_lite_fir_slave_gen #(
    parameter int NUM_COEFF  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         hsel,
    input  logic [ADDR_W-1:0]            haddr,
    input  logic [1:0]                   htrans,
    input  logic [2:0]                   hsize,
    input  logic                         hwrite,
    input  logic [15:0]                  hwdata,
    input  logic                         hready,
    output logic                         hreadyout,
    output logic                         hresp,
    output logic [15:0]                  hrdata,
    output logic [15:0]                  sample_data,
    output logic                         data_ready,
    input  logic                         processed,
    input  logic [$clog2(NUM_COEFF)-1:0] coefficient_num,
    output logic [15:0]                  fir_coefficient,
    output logic                         new_coefficient_set,
    input  logic                         clear_new_coefficient,
    input  logic                         modwait,
    input  logic                         err,
    input  logic [15:0]                  fir_out
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int CNW = $clog2(NUM_COEFF);

    // Registers are halfwords, so decode works on the halfword address.
    typedef logic [ADDR_W-2:0] hw_addr_t;

    localparam hw_addr_t          LP_HW_STATUS = hw_addr_t'(0);
    localparam hw_addr_t          LP_HW_RESULT = hw_addr_t'(1);
    localparam hw_addr_t          LP_HW_SAMPLE = hw_addr_t'(2);
    localparam hw_addr_t          LP_HW_COUNT  = hw_addr_t'(3);
    localparam hw_addr_t          LP_HW_SET    = hw_addr_t'(4 + NUM_COEFF);
    localparam logic [ADDR_W-1:0] LP_ADDR_LAST = ADDR_W'(8 + 2 * NUM_COEFF + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_dp_write;
    logic                r_dp_half;
    logic [ADDR_W-1:0]   r_dp_addr;
    hw_addr_t            w_dp_hw;
    hw_addr_t            w_ap_hw;

    logic [15:0]         r_coeff [NUM_COEFF];
    logic [15:0]         w_coeff_pad [2**CNW];
    logic                r_ncs;

    logic [15:0]         r_mem [FIFO_DEPTH];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;

    logic                w_ap_err;
    logic                w_take;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_stall;
    logic                w_wr;
    logic                w_set_wr;
    logic [15:0]         w_rdata;
    logic                w_unused;

    // NONSEQ/SEQ are treated alike; the low transfer-type bit carries no meaning here.
    assign w_unused = htrans[0];

    assign w_ap_hw = haddr[ADDR_W-1:1];
    assign w_dp_hw = r_dp_addr[ADDR_W-1:1];

    // Address-phase legality check; an illegal transfer never touches any register.
    always_comb begin
        w_ap_err = 1'b0;
        if (hsize[2:1] != 2'b00) begin
            w_ap_err = 1'b1;
        end
        if (haddr > LP_ADDR_LAST) begin
            w_ap_err = 1'b1;
        end
        if (hwrite && (w_ap_hw == LP_HW_STATUS || w_ap_hw == LP_HW_RESULT ||
                       w_ap_hw == LP_HW_COUNT)) begin
            w_ap_err = 1'b1;
        end
        if (hwrite && (hsize == 3'd0) && (w_ap_hw == LP_HW_SAMPLE)) begin
            w_ap_err = 1'b1;
        end
    end

    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_pop   = processed && (r_count != '0);
    // A full FIFO only stalls the sample write when no pop frees an entry this cycle.
    assign w_stall = (r_state == ST_DATA) && r_dp_write && (w_dp_hw == LP_HW_SAMPLE) &&
                     w_full && !w_pop;

    // Bus response derived from the current state.
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (r_state)
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            ST_ERR2: hresp = 1'b1;
            ST_DATA: hreadyout = !w_stall;
            default: ;
        endcase
    end

    assign w_take = hsel && htrans[1] && hready && hreadyout;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a new address phase is only taken once the current data phase completes.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_ERR1) begin
            w_state_nxt = ST_ERR2;
        end else if (hreadyout) begin
            if (w_take) begin
                w_state_nxt = w_ap_err ? ST_ERR1 : ST_DATA;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    // Capture address-phase attributes for use in the following data phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dp_write <= 1'b0;
            r_dp_half  <= 1'b0;
            r_dp_addr  <= '0;
        end else if (w_take) begin
            r_dp_write <= hwrite;
            r_dp_half  <= (hsize == 3'd1);
            r_dp_addr  <= haddr;
        end
    end

    assign w_wr     = (r_state == ST_DATA) && r_dp_write && hreadyout;
    assign w_push   = w_wr && (w_dp_hw == LP_HW_SAMPLE);
    assign w_set_wr = w_wr && (w_dp_hw == LP_HW_SET) && (r_dp_half || !r_dp_addr[0]);

    // Coefficient bank; byte writes land only in the addressed byte lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_COEFF; k++) begin
                r_coeff[k] <= '0;
            end
        end else if (w_wr) begin
            for (int k = 0; k < NUM_COEFF; k++) begin
                if (w_dp_hw == hw_addr_t'(4 + k)) begin
                    if (r_dp_half) begin
                        r_coeff[k] <= hwdata;
                    end else if (r_dp_addr[0]) begin
                        r_coeff[k][15:8] <= hwdata[15:8];
                    end else begin
                        r_coeff[k][7:0] <= hwdata[7:0];
                    end
                end
            end
        end
    end

    // Coefficient-set flag; a bus write beats a simultaneous clear from the controller.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ncs <= 1'b0;
        end else if (w_set_wr) begin
            r_ncs <= hwdata[0];
        end else if (clear_new_coefficient) begin
            r_ncs <= 1'b0;
        end
    end

    assign new_coefficient_set = r_ncs;

    // Pad the bank to a power of two so an out-of-range select reads as zero.
    for (genvar g = 0; g < 2**CNW; g++) begin : g_pad
        if (g < NUM_COEFF) begin : g_real
            assign w_coeff_pad[g] = r_coeff[g];
        end else begin : g_zero
            assign w_coeff_pad[g] = '0;
        end
    end

    assign fir_coefficient = w_coeff_pad[coefficient_num];

    // Sample storage; contents need no reset because data_ready gates the head.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= hwdata;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    assign data_ready  = (r_count != '0);
    assign sample_data = data_ready ? r_mem[r_rd_ptr] : '0;

    // Read mux straight from the registers, so a read right after a write sees the new value.
    always_comb begin
        w_rdata = '0;
        if ((r_state == ST_DATA) && !r_dp_write) begin
            if (w_dp_hw == LP_HW_STATUS) begin
                w_rdata = {7'b0, err, 7'b0, (modwait | r_ncs)};
            end else if (w_dp_hw == LP_HW_RESULT) begin
                w_rdata = fir_out;
            end else if (w_dp_hw == LP_HW_COUNT) begin
                w_rdata = 16'(r_count);
            end else if (w_dp_hw == LP_HW_SET) begin
                w_rdata = {15'b0, r_ncs};
            end
            for (int k = 0; k < NUM_COEFF; k++) begin
                if (w_dp_hw == hw_addr_t'(4 + k)) begin
                    w_rdata = r_coeff[k];
                end
            end
        end
    end

    assign hrdata = w_rdata;

endmodule

// File: tb/tb_ahb_lite_fir_slave_gen.sv
// Directed bench for the FIR AHB-Lite slave front-end (default parameters:
// 4 coefficients, 4-entry FIFO, coef-set register at byte address 0x10).
module tb_ahb_lite_fir_slave_gen;

    logic        clk;
    logic        rst;
    logic        hsel;
    logic [4:0]  haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [15:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [15:0] hrdata;
    logic [15:0] sample_data;
    logic        data_ready;
    logic        processed;
    logic [1:0]  coefficient_num;
    logic [15:0] fir_coefficient;
    logic        new_coefficient_set;
    logic        clear_new_coefficient;
    logic        modwait;
    logic        err;
    logic [15:0] fir_out;

    int total = 0;
    int bad   = 0;
    logic [15:0] rdv;

    assign hready = hreadyout;

    ahb_lite_fir_slave_gen dut (
        .clk                   (clk),
        .rst                   (rst),
        .hsel                  (hsel),
        .haddr                 (haddr),
        .htrans                (htrans),
        .hsize                 (hsize),
        .hwrite                (hwrite),
        .hwdata                (hwdata),
        .hready                (hready),
        .hreadyout             (hreadyout),
        .hresp                 (hresp),
        .hrdata                (hrdata),
        .sample_data           (sample_data),
        .data_ready            (data_ready),
        .processed             (processed),
        .coefficient_num       (coefficient_num),
        .fir_coefficient       (fir_coefficient),
        .new_coefficient_set   (new_coefficient_set),
        .clear_new_coefficient (clear_new_coefficient),
        .modwait               (modwait),
        .err                   (err),
        .fir_out               (fir_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [4:0] a, input logic w, input logic [2:0] sz);
        hsel   = 1'b1;
        htrans = 2'd2;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
    endtask

    task automatic idle();
        hsel   = 1'b0;
        htrans = 2'd0;
        hwrite = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [2:0] sz, input logic [15:0] d);
        bus(a, 1'b1, sz);
        tick();
        hwdata = d;
        idle();
        tick();
    endtask

    task automatic rd(input logic [4:0] a, output logic [15:0] d);
        bus(a, 1'b0, 3'd1);
        tick();
        idle();
        @(negedge clk);
        d = hrdata;
        tick();
    endtask

    task automatic err_case(input string tag, input logic [4:0] a, input logic w, input logic [2:0] sz);
        bus(a, w, sz);
        tick();
        hwdata = 16'hFFFF;
        idle();
        @(negedge clk);
        chk({tag, "_rdy1"}, 16'(hreadyout), 16'd0);
        chk({tag, "_rsp1"}, 16'(hresp), 16'd1);
        tick();
        @(negedge clk);
        chk({tag, "_rdy2"}, 16'(hreadyout), 16'd1);
        chk({tag, "_rsp2"}, 16'(hresp), 16'd1);
        tick();
        @(negedge clk);
        chk({tag, "_rsp_end"}, 16'(hresp), 16'd0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        hsel = 1'b0; haddr = '0; htrans = 2'd0; hsize = 3'd1; hwrite = 1'b0; hwdata = '0;
        processed = 1'b0; coefficient_num = 2'd0; clear_new_coefficient = 1'b0;
        modwait = 1'b0; err = 1'b0; fir_out = 16'hC0DE;

        // reset state
        tick();
        @(negedge clk);
        chk("rst_hreadyout", 16'(hreadyout), 16'd1);
        chk("rst_hresp", 16'(hresp), 16'd0);
        chk("rst_hrdata", hrdata, 16'd0);
        chk("rst_data_ready", 16'(data_ready), 16'd0);
        chk("rst_ncs", 16'(new_coefficient_set), 16'd0);
        chk("rst_coeff", fir_coefficient, 16'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: write coeff0 then read it back-to-back
        bus(5'h08, 1'b1, 3'd1);
        tick();
        hwdata = 16'h1234;
        bus(5'h08, 1'b0, 3'd1);
        @(negedge clk);
        chk("t1_wr_rdy", 16'(hreadyout), 16'd1);
        tick();
        idle();
        @(negedge clk);
        chk("t1_rd_data", hrdata, 16'h1234);
        chk("t1_rd_rdy", 16'(hreadyout), 16'd1);
        tick();
        @(negedge clk);
        chk("t1_idle_hrdata", hrdata, 16'd0);
        tick();

        // 2: coefficient 3 through the selector, byte write to coeff0 high lane
        coefficient_num = 2'd3;
        wr(5'h0E, 3'd1, 16'hBEEF);
        @(negedge clk);
        chk("t2_coeff3", fir_coefficient, 16'hBEEF);
        tick();
        wr(5'h09, 3'd0, 16'hAB55);
        coefficient_num = 2'd0;
        @(negedge clk);
        chk("t2_byte_hi", fir_coefficient, 16'hAB34);
        tick();
        rd(5'h02, rdv);
        chk("t2_result", rdv, 16'hC0DE);

        // 3: fill FIFO, stall fifth write, release with one pop
        wr(5'h04, 3'd1, 16'h1111);
        wr(5'h04, 3'd1, 16'h2222);
        wr(5'h04, 3'd1, 16'h3333);
        wr(5'h04, 3'd1, 16'h4444);
        @(negedge clk);
        chk("t3_ready", 16'(data_ready), 16'd1);
        chk("t3_head", sample_data, 16'h1111);
        tick();
        rd(5'h06, rdv);
        chk("t3_count4", rdv, 16'd4);
        rd(5'h04, rdv);
        chk("t3_sample_rd0", rdv, 16'd0);
        bus(5'h04, 1'b1, 3'd1);
        tick();
        hwdata = 16'h5555;
        idle();
        @(negedge clk);
        chk("t3_stall0", 16'(hreadyout), 16'd0);
        tick();
        @(negedge clk);
        chk("t3_stall1", 16'(hreadyout), 16'd0);
        tick();
        processed = 1'b1;
        @(negedge clk);
        chk("t3_release", 16'(hreadyout), 16'd1);
        tick();
        processed = 1'b0;
        @(negedge clk);
        chk("t3_head2", sample_data, 16'h2222);
        tick();
        rd(5'h06, rdv);
        chk("t3_count_after", rdv, 16'd4);

        // 4: ERROR responses
        modwait = 1'b1;
        err = 1'b1;
        err_case("t4_ro", 5'h00, 1'b1, 3'd1);
        rd(5'h00, rdv);
        chk("t4_status", rdv, 16'h0101);
        modwait = 1'b0;
        err = 1'b0;
        err_case("t4_size", 5'h08, 1'b1, 3'd2);
        rd(5'h08, rdv);
        chk("t4_coeff_kept", rdv, 16'hAB34);
        err_case("t4_addr", 5'h12, 1'b0, 3'd1);
        err_case("t4_byte_sample", 5'h04, 1'b1, 3'd0);
        rd(5'h06, rdv);
        chk("t4_count_kept", rdv, 16'd4);

        // 5: set flag wins over simultaneous clear, later clear drops it
        bus(5'h10, 1'b1, 3'd1);
        tick();
        hwdata = 16'h0001;
        clear_new_coefficient = 1'b1;
        idle();
        tick();
        clear_new_coefficient = 1'b0;
        @(negedge clk);
        chk("t5_ncs_set", 16'(new_coefficient_set), 16'd1);
        tick();
        rd(5'h00, rdv);
        chk("t5_status_bit0", rdv, 16'h0001);
        rd(5'h10, rdv);
        chk("t5_set_rd", rdv, 16'h0001);
        clear_new_coefficient = 1'b1;
        tick();
        clear_new_coefficient = 1'b0;
        @(negedge clk);
        chk("t5_ncs_clr", 16'(new_coefficient_set), 16'd0);
        tick();

        // 6: reset in the middle of a stalled sample write
        coefficient_num = 2'd3;
        bus(5'h04, 1'b1, 3'd1);
        tick();
        hwdata = 16'h6666;
        idle();
        @(negedge clk);
        chk("t6_stall", 16'(hreadyout), 16'd0);
        rst = 1'b1;
        #1;
        chk("t6_rst_rdy", 16'(hreadyout), 16'd1);
        chk("t6_rst_dready", 16'(data_ready), 16'd0);
        chk("t6_rst_coeff", fir_coefficient, 16'd0);
        chk("t6_rst_hresp", 16'(hresp), 16'd0);
        tick();
        tick();
        rst = 1'b0;
        processed = 1'b1;
        tick();
        processed = 1'b0;
        @(negedge clk);
        chk("t6_empty_pop", 16'(data_ready), 16'd0);
        tick();
        rd(5'h06, rdv);
        chk("t6_count0", rdv, 16'd0);
        rd(5'h0E, rdv);
        chk("t6_coeff3_rd", rdv, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
